// File: rtl/edt_pkg.sv
// Shared constants and helpers for the event delay tracker.
package edt_pkg;

  localparam int BYPASS_REG  = 0;
  localparam int BYPASS_COMB = 1;

  // All-ones value for a counter of the given width; capped at 64 bits.
  function automatic logic [63:0] cnt_max(input int unsigned width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/event_delay_chan.sv
// One tracker channel: saturating elapsed-clock counter, first/seen flags,
// sampled condition and the delay compare.
module event_delay_chan
  import edt_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int BYPASS = BYPASS_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic             condition,
  input  logic             clr,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] num,
  output logic             no_signal_yet,
  output logic             hit,
  output logic             first,
  output logic             cond_out,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             first_done_q, first_done_d;
  logic             cond_q, cond_d;

  always_comb begin
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    first_done_d = first_done_q;
    cond_d       = cond_q;
    if (clr) begin
      cnt_d        = '0;
      seen_d       = 1'b0;
      first_done_d = 1'b0;
      cond_d       = 1'b0;
    end else if (signal) begin
      cnt_d        = CNT_W'(1);
      seen_d       = 1'b1;
      first_done_d = 1'b1;
      cond_d       = condition;
    end else if (cnt_q != CntMax) begin
      // Counting continues while never signalled; saturated masks that case.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      first_done_q <= 1'b0;
      cond_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      first_done_q <= first_done_d;
      cond_q       <= cond_d;
    end
  end

  generate
    if (BYPASS == BYPASS_COMB) begin : g_comb
      assign num           = signal ? '0 : cnt_q;
      assign no_signal_yet = signal ? 1'b0 : ~seen_q;
      assign cond_out      = signal ? condition : cond_q;
    end else begin : g_reg
      assign num           = cnt_q;
      assign no_signal_yet = ~seen_q;
      assign cond_out      = cond_q;
    end
  endgenerate

  assign hit       = ~no_signal_yet & (num == target);
  assign first     = signal & ~first_done_q;
  assign saturated = seen_q & (cnt_q == CntMax);

endmodule

// File: rtl/event_delay_tracker.sv
// Multi-channel elapsed-clock tracker: NCH independent channels plus the
// any_hit reduction.
module event_delay_tracker
  import edt_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int BYPASS = BYPASS_REG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       signal,
  input  logic [NCH-1:0]       condition,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH*CNT_W-1:0] target,
  output logic [NCH*CNT_W-1:0] num,
  output logic [NCH-1:0]       no_signal_yet,
  output logic [NCH-1:0]       hit,
  output logic [NCH-1:0]       first,
  output logic [NCH-1:0]       cond_out,
  output logic [NCH-1:0]       saturated,
  output logic                 any_hit
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    event_delay_chan #(
      .CNT_W  (CNT_W),
      .BYPASS (BYPASS)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .signal        (signal[c]),
      .condition     (condition[c]),
      .clr           (clr[c]),
      .target        (target[c*CNT_W +: CNT_W]),
      .num           (num[c*CNT_W +: CNT_W]),
      .no_signal_yet (no_signal_yet[c]),
      .hit           (hit[c]),
      .first         (first[c]),
      .cond_out      (cond_out[c]),
      .saturated     (saturated[c])
    );
  end

  assign any_hit = |hit;

endmodule
